// File: rtl/ecdhe_pkg.sv
// Shared ECDHE/TLS constants, serializer state encoding and the KeyShareEntry header byte table.
package ecdhe_pkg;

    localparam logic [15:0] TLS_GROUP_SECP256R1   = 16'h0017;
    localparam logic [7:0]  EC_POINT_UNCOMPRESSED = 8'h04;
    localparam int unsigned EC_COORD_BYTES        = 32;
    localparam int unsigned EC_POINT_BYTES        = 65;
    localparam int unsigned KEYSHARE_HDR_BYTES    = 4;
    localparam int unsigned KEY_BITS              = 2 * EC_COORD_BYTES * 8;
    localparam int unsigned CNT_W                 = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Non-coordinate bytes: group code, 16-bit point length, then the uncompressed marker.
    function automatic logic [7:0] hdr_byte(input logic [CNT_W-1:0] idx,
                                            input logic [15:0]      group,
                                            input logic             with_hdr);
        logic [CNT_W-1:0] pos;
        pos = with_hdr ? idx : idx + CNT_W'(KEYSHARE_HDR_BYTES);
        case (pos)
            CNT_W'(0): hdr_byte = group[15:8];
            CNT_W'(1): hdr_byte = group[7:0];
            CNT_W'(2): hdr_byte = 8'(EC_POINT_BYTES >> 8);
            CNT_W'(3): hdr_byte = 8'(EC_POINT_BYTES);
            default:   hdr_byte = EC_POINT_UNCOMPRESSED;
        endcase
    endfunction

endpackage

// File: rtl/ecdhe_keyshare_serializer.sv
// Serializes one captured P-256 public key into a TLS 1.3 KeyShareEntry byte stream
// over valid/ready; the key is held internally so the generator may restart meanwhile.
module ecdhe_keyshare_serializer
    import ecdhe_pkg::*;
#(
    parameter logic [15:0] NAMED_GROUP    = TLS_GROUP_SECP256R1,
    parameter bit          INCLUDE_HEADER = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [KEY_BITS-1:0] public_key,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    output logic                tx_last,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam int unsigned      HDR_BYTES   = INCLUDE_HEADER ? KEYSHARE_HDR_BYTES : 32'd0;
    localparam logic [CNT_W-1:0] FIRST_COORD = CNT_W'(HDR_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(HDR_BYTES + EC_POINT_BYTES - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [KEY_BITS-1:0] r_shift;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_tx_last;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;
    logic                r_kv_q;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [KEY_BITS-1:0] w_shift_nxt;
    logic [7:0]          w_tx_data_nxt;
    logic                w_tx_valid_nxt;
    logic                w_tx_last_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_overrun_nxt;

    logic                w_rise;
    logic                w_hs;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [KEY_BITS-1:0] w_shift_adv;
    logic [7:0]          w_next_byte;

    assign w_rise    = key_valid & ~r_kv_q;
    assign w_hs      = r_tx_valid & tx_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Shift only once a coordinate byte leaves, so the top byte is always the next X/Y byte.
    assign w_shift_adv = (r_cnt >= FIRST_COORD) ? {r_shift[KEY_BITS-9:0], 8'h00} : r_shift;
    assign w_next_byte = (w_cnt_inc < FIRST_COORD)
                       ? hdr_byte(w_cnt_inc, NAMED_GROUP, INCLUDE_HEADER)
                       : w_shift_adv[KEY_BITS-1 -: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_kv_q     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_last  <= w_tx_last_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_overrun  <= w_overrun_nxt;
            r_kv_q     <= key_valid;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_last_nxt  = r_tx_last;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_overrun_nxt  = r_overrun;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt    = SEND;
                    w_cnt_nxt      = '0;
                    w_shift_nxt    = public_key;
                    w_tx_data_nxt  = hdr_byte('0, NAMED_GROUP, INCLUDE_HEADER);
                    w_tx_valid_nxt = 1'b1;
                    w_tx_last_nxt  = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            SEND: begin
                // A new key while streaming is dropped and flagged.
                if (w_rise) begin
                    w_overrun_nxt = 1'b1;
                end
                if (w_hs) begin
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt    = IDLE;
                        w_cnt_nxt      = '0;
                        w_tx_data_nxt  = '0;
                        w_tx_valid_nxt = 1'b0;
                        w_tx_last_nxt  = 1'b0;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                    end else begin
                        w_cnt_nxt      = w_cnt_inc;
                        w_shift_nxt    = w_shift_adv;
                        w_tx_data_nxt  = w_next_byte;
                        w_tx_last_nxt  = (w_cnt_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign tx_last  = r_tx_last;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;

endmodule
